sound_event_arbiter: RTL and testbench

- Shares the single piezo/speaker output among the game controller's one-cycle event pulses: hit, wall and goal.
- Latches each event as pending and arbitrates by fixed priority.
- Sequences each event as one or more square-wave beeps with inter-beep gaps.
- Sits between the game controller's event outputs and the board speaker pin.

---
 rtl/sound_event_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sound_event_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sound_event_arbiter.sv
// rtl/sound_event_arbiter.sv - priority-arbitrated beep sequencer for the single speaker pin
// Define WIN_MELODY_EN to add the four-note win melody started by a rising edge of win_i.
module sound_event_arbiter #(
  parameter int TONE_LEN = 2500000,
  parameter int GAP_LEN  = 250000,
  parameter int HIT_DIV  = 50000,
  parameter int WALL_DIV = 25000,
  parameter int GOAL_DIV = 12500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hit_i,
  input  logic       wall_i,
  input  logic       goal_i,
  input  logic       win_i,
  input  logic       mute_i,
  output logic       speaker_o,
  output logic       busy_o,
  output logic [1:0] cur_event_o
);

  localparam int MAX_HW  = (HIT_DIV > WALL_DIV) ? HIT_DIV : WALL_DIV;
  localparam int MAX_DIV = (MAX_HW > GOAL_DIV) ? MAX_HW : GOAL_DIV;
  localparam int MAX_LEN = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
  localparam int DW      = $clog2(MAX_DIV + 1);
  localparam int TW      = $clog2(MAX_LEN + 1);

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_LEN - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_LEN - 1);
  localparam logic [DW-1:0] D_HIT     = DW'(HIT_DIV);
  localparam logic [DW-1:0] D_WALL    = DW'(WALL_DIV);
  localparam logic [DW-1:0] D_GOAL    = DW'(GOAL_DIV);

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_WALL = 2'b01;
  localparam logic [1:0] EV_HIT  = 2'b10;
  localparam logic [1:0] EV_GOAL = 2'b11;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t        state_q;
  logic [2:0]    pend_q, pend_d;
  logic [1:0]    ev_q, sel_ev;
  logic [1:0]    beeps_q, sel_beeps;
  logic [DW-1:0] div_q, sel_div, cnt_q, cnt_d, mel_div;
  logic [TW-1:0] tmr_q;
  logic          spk_q;
  logic          any_pend, preempt, gap_end, launch, toggle;
  logic          win_pend, mel_more;

  // pend_q is {goal, hit, wall}; a new pulse wins over the clear of its own bit
  always_comb begin
    any_pend  = win_pend || (pend_q != 3'b000);
    sel_ev    = EV_NONE;
    sel_beeps = 2'd0;
    sel_div   = D_WALL;
    if (win_pend) begin
      sel_ev = EV_GOAL; sel_beeps = 2'd1; sel_div = D_HIT;
    end else if (pend_q[2]) begin
      sel_ev = EV_GOAL; sel_beeps = 2'd3; sel_div = D_GOAL;
    end else if (pend_q[1]) begin
      sel_ev = EV_HIT;  sel_beeps = 2'd1; sel_div = D_HIT;
    end else if (pend_q[0]) begin
      sel_ev = EV_WALL; sel_beeps = 2'd1; sel_div = D_WALL;
    end
    gap_end = (state_q == GAP) && (tmr_q == GAP_LAST) && (beeps_q == 2'd1);
    preempt = (state_q != IDLE) && (win_pend || (pend_q[2] && (ev_q != EV_GOAL)));
    launch  = any_pend && ((state_q == IDLE) || gap_end || preempt);
    pend_d  = pend_q;
    if (launch) begin
      if (win_pend)       pend_d = 3'b000;
      else if (pend_q[2]) pend_d[2] = 1'b0;
      else if (pend_q[1]) pend_d[1] = 1'b0;
      else                pend_d[0] = 1'b0;
    end
    pend_d = pend_d | {goal_i, hit_i, wall_i};
    cnt_d  = (cnt_q == div_q - 1'b1) ? '0 : cnt_q + 1'b1;
    toggle = (cnt_d == div_q - 1'b1);
  end

`ifdef WIN_MELODY_EN
  localparam logic [DW-1:0] D_HALF = DW'(GOAL_DIV / 2);
  logic       win_prev_q, win_pend_q, mel_q;
  logic [1:0] note_q;

  assign win_pend = win_pend_q;
  assign mel_more = mel_q && (note_q != 2'd3);

  // divider for the note that follows note_q
  always_comb begin
    case (note_q)
      2'd0:    mel_div = D_WALL;
      2'd1:    mel_div = D_GOAL;
      default: mel_div = D_HALF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_prev_q <= 1'b0; win_pend_q <= 1'b0; mel_q <= 1'b0; note_q <= 2'd0;
    end else if (mute_i) begin
      win_prev_q <= win_i; win_pend_q <= 1'b0; mel_q <= 1'b0; note_q <= 2'd0;
    end else begin
      win_prev_q <= win_i;
      win_pend_q <= (win_pend_q && !launch) || (win_i && !win_prev_q);
      if (launch) begin
        mel_q  <= win_pend_q;
        note_q <= 2'd0;
      end else if ((state_q == TONE) && (tmr_q == TONE_LAST) && mel_more) begin
        note_q <= note_q + 1'b1;
      end
    end
  end
`else
  logic unused_win;
  assign unused_win = win_i;
  assign win_pend   = 1'b0;
  assign mel_more   = 1'b0;
  assign mel_div    = '0;
`endif

  // outputs trail the sequencer by one register stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE; pend_q <= '0; ev_q <= EV_NONE; beeps_q <= '0;
      div_q <= '0; cnt_q <= '0; tmr_q <= '0; spk_q <= 1'b0;
      speaker_o <= 1'b0; busy_o <= 1'b0; cur_event_o <= EV_NONE;
    end else if (mute_i) begin
      state_q <= IDLE; pend_q <= '0; ev_q <= EV_NONE; beeps_q <= '0;
      div_q <= '0; cnt_q <= '0; tmr_q <= '0; spk_q <= 1'b0;
      speaker_o <= 1'b0; busy_o <= 1'b0; cur_event_o <= EV_NONE;
    end else begin
      speaker_o   <= spk_q;
      busy_o      <= (state_q != IDLE);
      cur_event_o <= ev_q;
      pend_q      <= pend_d;
      if (launch) begin
        state_q <= TONE; ev_q <= sel_ev; beeps_q <= sel_beeps; div_q <= sel_div;
        cnt_q <= '0; tmr_q <= '0; spk_q <= 1'b0;
      end else begin
        case (state_q)
          TONE: begin
            cnt_q <= cnt_d;
            if (toggle) spk_q <= ~spk_q;
            if (tmr_q == TONE_LAST) begin
              tmr_q <= '0;
              if (mel_more) begin
                div_q <= mel_div;
                cnt_q <= '0;
              end else begin
                state_q <= GAP;
                spk_q   <= 1'b0;
              end
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          GAP: begin
            if (tmr_q == GAP_LAST) begin
              tmr_q   <= '0;
              cnt_q   <= '0;
              beeps_q <= beeps_q - 1'b1;
              if (beeps_q == 2'd1) begin
                state_q <= IDLE;
                ev_q    <= EV_NONE;
              end else begin
                state_q <= TONE;
              end
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb/tb_sound_event_arbiter.sv - directed vector bench for sound_event_arbiter
module tb_sound_event_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       hit = 1'b0, wall = 1'b0, goal = 1'b0, win = 1'b0, mute = 1'b0;
  logic       speaker, busy;
  logic [1:0] cur_event;
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  sound_event_arbiter #(.TONE_LEN(20), .GAP_LEN(6), .HIT_DIV(4), .WALL_DIV(3), .GOAL_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .hit_i(hit), .wall_i(wall), .goal_i(goal), .win_i(win),
    .mute_i(mute), .speaker_o(speaker), .busy_o(busy), .cur_event_o(cur_event)
  );

  typedef struct {
    logic       hit, wall, goal;
    int         n;
    logic       spk, busy;
    logic [1:0] cur;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic h, input logic w, input logic g, input int n,
                              input logic s, input logic b, input logic [1:0] c);
    vec_t v;
    v.hit = h; v.wall = w; v.goal = g; v.n = n; v.spk = s; v.busy = b; v.cur = c;
    vecs.push_back(v);
  endfunction

  // hit beep outputs from two edges after the pulse: toggles every 4, then a 6-cycle gap
  function automatic void add_hit_body();
    add(0, 0, 0, 3, 0, 1, 2'b10);
    add(0, 0, 0, 4, 1, 1, 2'b10);
    add(0, 0, 0, 4, 0, 1, 2'b10);
    add(0, 0, 0, 4, 1, 1, 2'b10);
    add(0, 0, 0, 4, 0, 1, 2'b10);
    add(0, 0, 0, 1, 1, 1, 2'b10);
    add(0, 0, 0, 6, 0, 1, 2'b10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input logic [1:0] cur_exp, output int busy_n, output int rises,
                         output int bad_cur);
    logic prev;
    prev = speaker; busy_n = 0; rises = 0; bad_cur = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      busy_n++;
      if (cur_event !== cur_exp) bad_cur++;
      tick();
      if (speaker && !prev) rises++;
      prev = speaker;
    end
  endtask

  task automatic quiet(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick();
      if (busy || speaker || cur_event != 2'b00) hi++;
    end
  endtask

  int bn, rs, bc, hi;

  initial begin
    // scenario 1: lone hit pulse
    add(1, 0, 0, 2, 0, 0, 2'b00);
    add_hit_body();
    add(0, 0, 0, 4, 0, 0, 2'b00);
    // scenario 2: hit and wall together, wall follows straight after hit's gap
    add(1, 1, 0, 2, 0, 0, 2'b00);
    add_hit_body();
    add(0, 0, 0, 2, 0, 1, 2'b01);
    add(0, 0, 0, 3, 1, 1, 2'b01);
    add(0, 0, 0, 3, 0, 1, 2'b01);
    add(0, 0, 0, 3, 1, 1, 2'b01);
    add(0, 0, 0, 3, 0, 1, 2'b01);
    add(0, 0, 0, 3, 1, 1, 2'b01);
    add(0, 0, 0, 9, 0, 1, 2'b01);
    add(0, 0, 0, 4, 0, 0, 2'b00);

    repeat (3) tick();
    chk("reset speaker", speaker, 0);
    chk("reset busy", busy, 0);
    chk("reset cur_event", cur_event, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle busy", busy, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      for (int i = 0; i < vecs[r].n; i++) begin
        hit  = vecs[r].hit  && (i == 0);
        wall = vecs[r].wall && (i == 0);
        goal = vecs[r].goal && (i == 0);
        tick();
        hit = 1'b0; wall = 1'b0; goal = 1'b0;
        chk($sformatf("vec r%0d c%0d speaker", r, i), speaker, vecs[r].spk);
        chk($sformatf("vec r%0d c%0d busy", r, i), busy, vecs[r].busy);
        chk($sformatf("vec r%0d c%0d cur_event", r, i), cur_event, vecs[r].cur);
      end
    end

    // goal preempts a hit five cycles into its tone
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (5) tick();
    goal = 1'b1; tick(); goal = 1'b0;
    chk("preempt cur before", cur_event, 2'b10);
    tick();
    chk("preempt cur edge+1", cur_event, 2'b10);
    tick();
    chk("preempt cur edge+2", cur_event, 2'b11);
    chk("preempt busy edge+2", busy, 1);
    measure(2'b11, bn, rs, bc);
    chk("goal busy cycles", bn, 78);
    chk("goal speaker rises", rs, 15);
    chk("goal cur steady", bc, 0);
    chk("goal busy ended", busy, 0);
    quiet(30, hi);
    chk("hit not replayed", hi, 0);

    // mute during the second goal beep, wall pulse while muted
    goal = 1'b1; tick(); goal = 1'b0;
    repeat (33) tick();
    chk("pre-mute speaker", speaker, 1);
    chk("pre-mute busy", busy, 1);
    chk("pre-mute cur", cur_event, 2'b11);
    mute = 1'b1; wall = 1'b1;
    tick();
    wall = 1'b0;
    chk("mute speaker", speaker, 0);
    chk("mute busy", busy, 0);
    chk("mute cur", cur_event, 0);
    tick();
    wall = 1'b1; tick(); wall = 1'b0;
    tick();
    mute = 1'b0;
    quiet(40, hi);
    chk("post-mute silent", hi, 0);

    // asynchronous reset mid-tone with wall still pending
    hit = 1'b1; wall = 1'b1; tick(); hit = 1'b0; wall = 1'b0;
    repeat (5) tick();
    chk("pre-reset speaker", speaker, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset speaker", speaker, 0);
    chk("async reset busy", busy, 0);
    chk("async reset cur", cur_event, 0);
    tick();
    rst = 1'b0;
    quiet(40, hi);
    chk("post-reset silent", hi, 0);

`ifdef WIN_MELODY_EN
    wall = 1'b1; tick(); wall = 1'b0;
    repeat (4) tick();
    win = 1'b1; tick();
    tick();
    chk("win cur edge+1", cur_event, 2'b01);
    tick();
    chk("win cur edge+2", cur_event, 2'b11);
    measure(2'b11, bn, rs, bc);
    chk("win busy cycles", bn, 86);
    chk("win cur steady", bc, 0);
    quiet(40, hi);
    chk("win held no retrigger", hi, 0);
    win = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
